// File: rtl/usb_tx_sequencer.sv
// Burst transmit sequencer: streams an incrementing payload from a captured seed under
// valid/ready handshaking, with stall abort, accept history and a registered side adder.
module usb_tx_sequencer #(
    parameter int BURST_LEN  = 10,
    parameter int DATA_W     = 8,
    parameter int HIST_DEPTH = 10,
    parameter int ADD_W      = 1,
    parameter int STALL_MAX  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  send_data,
    input  logic [DATA_W-1:0]     seed,
    input  logic                  tx_ready,
    input  logic [ADD_W-1:0]      a,
    input  logic [ADD_W-1:0]      b,
    output logic                  tx_valid,
    output logic [DATA_W-1:0]     tx_data,
    output logic [9:0]            beat_cnt,
    output logic                  done,
    output logic                  err,
    output logic [HIST_DEPTH-1:0] hist,
    output logic [ADD_W:0]        sum
);

    localparam int              STALL_W     = $clog2(STALL_MAX + 1);
    localparam logic [9:0]      LAST_BEAT   = 10'(BURST_LEN - 1);
    localparam logic [9:0]      FULL_BURST  = 10'(BURST_LEN);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(STALL_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t             state;
    logic [STALL_W-1:0] stall_cnt;
    logic [STALL_W-1:0] stall_next;
    logic               accept;

    assign accept     = tx_valid & tx_ready;
    assign stall_next = stall_cnt + STALL_W'(1);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            beat_cnt  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            hist      <= '0;
            sum       <= '0;
            stall_cnt <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            hist <= {hist[HIST_DEPTH-2:0], accept};
            sum  <= {1'b0, a} + {1'b0, b};

            case (state)
                IDLE: begin
                    tx_valid  <= 1'b0;
                    stall_cnt <= '0;
                    if (send_data) begin
                        state    <= SEND;
                        tx_valid <= 1'b1;
                        tx_data  <= seed;
                        beat_cnt <= '0;
                    end
                end

                SEND: begin
                    // An accept always wins over the stall limit, so it is tested first.
                    if (accept) begin
                        stall_cnt <= '0;
                        if (beat_cnt == LAST_BEAT) begin
                            state    <= DONE;
                            tx_valid <= 1'b0;
                            beat_cnt <= FULL_BURST;
                            done     <= 1'b1;
                        end else begin
                            tx_data  <= tx_data + DATA_W'(1);
                            beat_cnt <= beat_cnt + 10'd1;
                        end
                    end else begin
                        stall_cnt <= stall_next;
                        if (stall_next == STALL_LIMIT) begin
                            state    <= ABORT;
                            tx_valid <= 1'b0;
                            err      <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end

                ABORT: begin
                    // beat_cnt keeps the partial count until the next burst starts.
                    state     <= IDLE;
                    stall_cnt <= '0;
                end

                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Directed bench for usb_tx_sequencer: expected payloads are queued when a burst starts
// and popped on every observed accept; outputs are sampled away from the rising edge.
module tb_usb_tx_sequencer;

    localparam int DATA_W     = 8;
    localparam int HIST_DEPTH = 10;
    localparam int ADD_W      = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  send_data;
    logic [DATA_W-1:0]     seed;
    logic                  tx_ready;
    logic [ADD_W-1:0]      a;
    logic [ADD_W-1:0]      b;
    logic                  tx_valid;
    logic [DATA_W-1:0]     tx_data;
    logic [9:0]            beat_cnt;
    logic                  done;
    logic                  err;
    logic [HIST_DEPTH-1:0] hist;
    logic [ADD_W:0]        sum;

    int checks     = 0;
    int errors     = 0;
    int done_seen  = 0;
    int err_seen   = 0;
    int done_base  = 0;
    int err_base   = 0;
    logic [DATA_W-1:0] prev_data;
    logic [DATA_W-1:0] sb_q[$];

    usb_tx_sequencer #(
        .BURST_LEN (10),
        .DATA_W    (DATA_W),
        .HIST_DEPTH(HIST_DEPTH),
        .ADD_W     (ADD_W),
        .STALL_MAX (16)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .send_data(send_data),
        .seed     (seed),
        .tx_ready (tx_ready),
        .a        (a),
        .b        (b),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .beat_cnt (beat_cnt),
        .done     (done),
        .err      (err),
        .hist     (hist),
        .sum      (sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic push_burst(input logic [DATA_W-1:0] start, input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(start + DATA_W'(i));
    endtask

    // One clock: watch the handshake at the falling edge, then return just after the rising edge.
    task automatic cycle();
        logic [DATA_W-1:0] expected;
        @(negedge clk);
        if (done) done_seen++;
        if (err) err_seen++;
        if (tx_valid && tx_ready) begin
            check("sb_has_entry", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                expected = sb_q.pop_front();
                check("sb_tx_data", tx_data, expected);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, tx_valid, 0);
        check({tag, "_data"},  tx_data,  0);
        check({tag, "_cnt"},   beat_cnt, 0);
        check({tag, "_done"},  done,     0);
        check({tag, "_err"},   err,      0);
        check({tag, "_hist"},  hist,     0);
        check({tag, "_sum"},   sum,      0);
    endtask

    initial begin
        rst_n     = 1'b0;
        send_data = 1'b0;
        tx_ready  = 1'b0;
        seed      = '0;
        a         = '0;
        b         = '0;
        #2;
        check_all_zero("rst");
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        check("idle_valid", tx_valid, 0);

        // Full burst with wrap, ready held high.
        seed = 8'hFE; tx_ready = 1'b1; send_data = 1'b1;
        cycle();
        send_data = 1'b0;
        check("a_start_valid", tx_valid, 1);
        check("a_start_data", tx_data, 8'hFE);
        check("a_start_cnt", beat_cnt, 0);
        push_burst(8'hFE, 10);
        repeat (9) cycle();
        check("a_last_data", tx_data, 8'h07);
        check("a_last_cnt", beat_cnt, 9);
        cycle();
        check("a_done", done, 1);
        check("a_done_valid", tx_valid, 0);
        check("a_done_cnt", beat_cnt, 10);
        check("a_done_hist", hist, 10'h3FF);
        check("a_sb_empty", sb_q.size(), 0);
        cycle();
        check("a_idle_done", done, 0);
        check("a_idle_cnt", beat_cnt, 0);
        check("a_idle_data", tx_data, 8'h07);
        check("a_idle_hist", hist, 10'h3FE);

        // Ready toggling 1,0,1,0: data must hold through every low cycle.
        seed = 8'h10; tx_ready = 1'b0; send_data = 1'b1;
        err_base = err_seen;
        cycle();
        send_data = 1'b0;
        push_burst(8'h10, 10);
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            tx_ready  = (i % 2 == 0);
            prev_data = tx_data;
            cycle();
            if (!tx_ready) begin
                check("b_stall_data", tx_data, prev_data);
                check("b_stall_valid", tx_valid, 1);
            end
        end
        check("b_done", done, 1);
        check("b_done_cnt", beat_cnt, 10);
        check("b_no_err", err_seen - err_base, 0);
        check("b_sb_empty", sb_q.size(), 0);
        tx_ready = 1'b1;
        cycle();

        // Three beats, then sixteen not-ready cycles abort the burst.
        seed = 8'h40; tx_ready = 1'b1; send_data = 1'b1;
        cycle();
        send_data = 1'b0;
        push_burst(8'h40, 3);
        repeat (3) cycle();
        check("c_cnt3", beat_cnt, 3);
        tx_ready = 1'b0;
        err_base = err_seen;
        repeat (15) cycle();
        check("c_15_err", err, 0);
        check("c_15_valid", tx_valid, 1);
        check("c_15_data", tx_data, 8'h43);
        cycle();
        check("c_abort_err", err, 1);
        check("c_abort_valid", tx_valid, 0);
        check("c_abort_cnt", beat_cnt, 3);
        cycle();
        check("c_after_err", err, 0);
        check("c_after_cnt", beat_cnt, 3);
        check("c_err_pulses", err_seen - err_base, 1);
        tx_ready = 1'b1;
        cycle();
        check("c_idle_valid", tx_valid, 0);
        check("c_sb_empty", sb_q.size(), 0);

        // Reset in the middle of a burst.
        a = 4'd3; b = 4'd4;
        seed = 8'h20; send_data = 1'b1;
        cycle();
        send_data = 1'b0;
        push_burst(8'h20, 10);
        repeat (5) cycle();
        check("d_cnt5", beat_cnt, 5);
        check("d_sum", sum, 7);
        done_base = done_seen;
        err_base  = err_seen;
        rst_n = 1'b0;
        #1;
        check_all_zero("d_rst");
        sb_q.delete();
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        check("d_no_done", done_seen - done_base, 0);
        check("d_no_err", err_seen - err_base, 0);
        check("d_idle_valid", tx_valid, 0);
        send_data = 1'b1;
        cycle();
        send_data = 1'b0;
        check("d_restart_data", tx_data, 8'h20);
        check("d_restart_cnt", beat_cnt, 0);
        push_burst(8'h20, 10);
        repeat (10) cycle();
        check("d_done", done, 1);
        cycle();

        // Adder: full-scale operands must not lose the carry.
        a = 4'd15; b = 4'd15;
        cycle();
        check("e_sum_30", sum, 30);
        a = 4'd0; b = 4'd0;
        cycle();
        check("e_sum_0", sum, 0);
        a = 4'd15; b = 4'd1;
        cycle();
        check("e_sum_16", sum, 16);

        // send_data held high: second burst only after IDLE is re-entered.
        seed = 8'h80; tx_ready = 1'b1; send_data = 1'b1;
        cycle();
        check("f_start_data", tx_data, 8'h80);
        push_burst(8'h80, 10);
        repeat (9) cycle();
        check("f_last_data", tx_data, 8'h89);
        check("f_last_valid", tx_valid, 1);
        cycle();
        check("f_done", done, 1);
        cycle();
        check("f_idle_valid", tx_valid, 0);
        check("f_idle_cnt", beat_cnt, 0);
        cycle();
        check("f_restart_valid", tx_valid, 1);
        check("f_restart_data", tx_data, 8'h80);
        check("f_restart_cnt", beat_cnt, 0);
        push_burst(8'h80, 10);
        send_data = 1'b0;
        repeat (10) cycle();
        check("f_done2", done, 1);
        cycle();
        check("f_sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_tx_sequencer.md
USB_TX_SEQUENCER -- requirements
Module: usb_tx_sequencer

Interface
REQ-001 Parameter BURST_LEN, default 10: number of accepted beats per burst (2..1023).
REQ-002 Parameter DATA_W, default 8: payload width in bits.
REQ-003 Parameter HIST_DEPTH, default 10: handshake history register depth (>=2).
REQ-004 Parameter ADD_W, default 1: adder operand width.
REQ-005 Parameter STALL_MAX, default 16: consecutive not-ready cycles before abort (>=1).
REQ-006 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-low reset.
REQ-008 Port send_data, input, 1: burst start request, sampled only in IDLE.
REQ-009 Port seed, input, DATA_W: first payload value, captured with send_data.
REQ-010 Port tx_ready, input, 1: sink ready.
REQ-011 Port a, input, ADD_W: adder operand.
REQ-012 Port b, input, ADD_W: adder operand.
REQ-013 Port tx_valid, output, 1: payload valid.
REQ-014 Port tx_data, output, DATA_W: payload.
REQ-015 Port beat_cnt, output, 10: beats accepted in the current burst.
REQ-016 Port done, output, 1: one-cycle pulse on burst completion.
REQ-017 Port err, output, 1: one-cycle pulse on stall abort.
REQ-018 Port hist, output, HIST_DEPTH: per-cycle accept history; bit 0 is newest.
REQ-019 Port sum, output, ADD_W+1: registered a+b.

Function
REQ-020 All outputs SHALL be registered; there are no combinational paths from inputs to outputs.
REQ-021 The state machine SHALL have states IDLE, SEND, DONE and ABORT; unreachable encodings SHALL go to IDLE with tx_valid=0.
REQ-022 A beat SHALL be accepted in any cycle where tx_valid=1 and tx_ready=1.
REQ-023 IDLE with send_data=1: next cycle SHALL be SEND, with tx_valid=1, tx_data=seed and beat_cnt=0 (latency 1 cycle).
REQ-024 IDLE with send_data=0: the block SHALL stay in IDLE with tx_valid=0 and tx_data holding its last value.
REQ-025 SEND, accepted beat that is not the last: tx_data SHALL increment by 1 (modulo 2^DATA_W, wrapping silently) and beat_cnt SHALL increment by 1.
REQ-026 SEND, tx_ready=0: tx_valid SHALL stay 1 and tx_data SHALL stay stable; valid is never withdrawn before acceptance.
REQ-027 A stall counter SHALL count consecutive SEND cycles with tx_ready=0 and SHALL clear on any accept.
REQ-028 When the stall counter reaches STALL_MAX, the next state SHALL be ABORT with tx_valid=0.
REQ-029 Accept of the beat with beat_cnt==BURST_LEN-1: next state SHALL be DONE, tx_valid=0, beat_cnt=BURST_LEN.
REQ-030 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE with beat_cnt cleared to 0.
REQ-031 ABORT SHALL assert err=1 for exactly one cycle, then go to IDLE; beat_cnt SHALL keep its partial value until the next burst starts.
REQ-032 send_data asserted outside IDLE SHALL be ignored and not queued.
REQ-033 Accept and stall-limit in the same cycle: accept wins and the stall counter clears.
REQ-034 Every cycle, hist SHALL shift left by one with bit 0 = (tx_valid & tx_ready); the oldest bit is discarded.
REQ-035 Every cycle, sum SHALL update to a+b zero-extended to ADD_W+1 bits, with no overflow loss.

Reset
REQ-036 While reset=0, the block SHALL immediately be in IDLE with tx_valid, tx_data, beat_cnt, done, err, hist, sum and the stall counter all 0.
REQ-037 Reset asserted mid-burst SHALL abort with no done or err pulse.
REQ-038 After reset deasserts, the first start is taken on the first rising edge that samples send_data=1.

Verification
REQ-039 Defaults, seed=8'hFE, tx_ready=1 held -> tx_data FE,FF,00,...,07 on 10 consecutive cycles; done pulse 1 cycle after the last; hist=10'h3FF at done.
REQ-040 tx_ready toggles 1,0,1,0... -> tx_data stable during each low cycle; burst completes with 10 accepts; err never asserted.
REQ-041 tx_ready=0 for 16 cycles after beat 3 -> err=1 one cycle; beat_cnt=3; tx_valid=0; IDLE.
REQ-042 reset pulsed low at beat 5 -> all outputs 0 immediately; no done or err; new burst after release starts at seed.
REQ-043 ADD_W=4, a=15, b=15 -> sum=5'd30 one cycle later; a=0, b=0 -> sum=0.
REQ-044 send_data=1 held throughout a burst -> a second burst starts in the cycle after IDLE is re-entered, not earlier.
